// File: rtl/rf_safe_shutdown.sv
// RF safe-shutdown controller: derates the carrier on watchdog warning, ramps it to zero on
// trigger and holds RF off until rearm. Define SHUTDOWN_AUTO_REARM_EN to leave SAFE without rearm.
module rf_safe_shutdown #(
  parameter int AMP_W       = 16,
  parameter int RAMP_STEP   = 256,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wdt_warning,
  input  logic             wdt_triggered,
  input  logic             rearm,
  input  logic [AMP_W-1:0] amp_in,
  output logic [AMP_W-1:0] amp_out,
  output logic             rf_enable,
  output logic [1:0]       state_o,
  output logic             shutdown_active,
  output logic [7:0]       fault_count
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [AMP_W-1:0] STEP      = AMP_W'(RAMP_STEP);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DERATE = 2'd1,
    ST_RAMP   = 2'd2,
    ST_SAFE   = 2'd3
  } state_t;

  state_t           state_q;
  logic [AMP_W-1:0] amp_q;
  logic             rf_enable_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             hold_done_q;
  logic [7:0]       fault_count_q;

  logic [AMP_W-1:0] amp_ramp_d;
  logic [CNT_W-1:0] hold_cnt_d;
  logic             rearm_ok_d;

  // Saturating ramp decrement and saturating hold counter
  always_comb begin
    amp_ramp_d = (amp_q > STEP) ? (amp_q - STEP) : '0;
    hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : (hold_cnt_q + CNT_W'(1));
  end

`ifdef SHUTDOWN_AUTO_REARM_EN
  assign rearm_ok_d = hold_done_q && !wdt_triggered;
`else
  assign rearm_ok_d = rearm && hold_done_q && !wdt_triggered;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_SAFE;
      amp_q         <= '0;
      rf_enable_q   <= 1'b0;
      hold_cnt_q    <= '0;
      hold_done_q   <= 1'b0;
      fault_count_q <= '0;
    end else begin
      case (state_q)
        ST_RUN, ST_DERATE: begin
          amp_q       <= (state_q == ST_RUN) ? amp_in : (amp_in >> 1);
          rf_enable_q <= 1'b1;
          if (wdt_triggered) begin
            state_q <= ST_RAMP;
            if (fault_count_q != 8'hFF) fault_count_q <= fault_count_q + 8'd1;
          end else if (wdt_warning) begin
            state_q <= ST_DERATE;
          end else begin
            state_q <= ST_RUN;
          end
        end
        // Ramp cannot be aborted; RF drops on the same edge amplitude reaches zero
        ST_RAMP: begin
          amp_q <= amp_ramp_d;
          if (amp_ramp_d == '0) begin
            state_q     <= ST_SAFE;
            rf_enable_q <= 1'b0;
          end
        end
        ST_SAFE: begin
          amp_q <= '0;
          if (rearm_ok_d) begin
            state_q     <= ST_RUN;
            rf_enable_q <= 1'b1;
            hold_cnt_q  <= '0;
            hold_done_q <= 1'b0;
          end else begin
            rf_enable_q <= 1'b0;
            hold_cnt_q  <= hold_cnt_d;
            hold_done_q <= (hold_cnt_d == HOLD_LAST);
          end
        end
        default: state_q <= ST_SAFE;
      endcase
    end
  end

  assign amp_out         = amp_q;
  assign rf_enable       = rf_enable_q;
  assign state_o         = state_q;
  assign shutdown_active = (state_q == ST_RAMP) || (state_q == ST_SAFE);
  assign fault_count     = fault_count_q;

endmodule

// File: doc/rf_safe_shutdown.md
Name: rf_safe_shutdown

Overview:
Downstream consumer of the watchdog timer's warning/triggered outputs; sits between the commanded AM carrier amplitude path and the DAC/RF output stage.
- Derates amplitude on watchdog warning.
- On watchdog trigger, ramps amplitude to zero in fixed steps, drops RF enable and holds a safe state.
- Leaves the safe state only on an explicit rearm once a minimum hold time has elapsed and the watchdog has cleared.

Parameters:
AMP_W, 16, width of amplitude input/output (unsigned)
RAMP_STEP, 256, decrement applied to amp_out per cycle in RAMP
HOLD_CYCLES, 1000, minimum cycles in SAFE before rearm is accepted (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
wdt_warning  in  1  watchdog warning level
wdt_triggered  in  1  watchdog timeout level
rearm  in  1  single-cycle rearm request from control plane
amp_in  in  AMP_W  commanded carrier amplitude
amp_out  out  AMP_W  registered amplitude to DAC scaler
rf_enable  out  1  RF output enable
state_o  out  2  current state: 0 RUN, 1 DERATE, 2 RAMP, 3 SAFE
shutdown_active  out  1  high in RAMP or SAFE
fault_count  out  8  count of entries into RAMP, saturating

Behaviour:
- Reset (async assert, sync release): state SAFE, amp_out=0, rf_enable=0, hold_cnt=0, hold_done=0, fault_count=0. After reset the block always needs HOLD_CYCLES plus a rearm before RF comes up.
- All outputs are registered; state_o and shutdown_active decode the state register.
- RUN: amp_out <= amp_in, giving 1-cycle latency. rf_enable=1.
- DERATE: amp_out <= amp_in >> 1 (logical shift). rf_enable=1.
- RAMP: amp_out <= (amp_out > RAMP_STEP) ? amp_out - RAMP_STEP : 0. Saturates at 0, never wraps. rf_enable stays 1 until the cycle SAFE is entered.
- SAFE: amp_out=0, rf_enable=0. hold_cnt counts up each cycle and saturates; hold_done=1 once hold_cnt reaches HOLD_CYCLES-1.
- Transition priority, evaluated each cycle; triggered outranks warning:
  - RUN: wdt_triggered -> RAMP; else wdt_warning -> DERATE.
  - DERATE: wdt_triggered -> RAMP; else !wdt_warning -> RUN.
  - RAMP: the next-cycle amp_out==0 -> SAFE. Deassertion of triggered or warning mid-ramp does not abort the ramp. rearm is ignored.
  - SAFE: rearm && hold_done && !wdt_triggered -> RUN, clearing hold_cnt and hold_done. rearm under any other condition is dropped, not latched. wdt_warning does not block rearm; if still high, the next cycle goes RUN -> DERATE.
- Entry into RAMP from the first amp value: RAMP decrements from the amp_out value held at the entry cycle. If amp_out is already 0 (or <= RAMP_STEP), the first RAMP cycle zeroes it and SAFE follows on the next cycle.
- fault_count increments by 1 on every RUN/DERATE -> RAMP transition and holds at 255. Only rst clears it.
- rst asserted mid-RAMP or mid-SAFE forces the reset values immediately, with no ramp completion.

Optional Feature:
SHUTDOWN_AUTO_REARM_EN:
- Defined: SAFE -> RUN happens automatically when hold_done && !wdt_triggered; the rearm input is ignored. This also applies after reset.
- Undefined: rearm is required exactly as described in Behaviour.

Test Plan:
- Bench parameters: AMP_W=16, RAMP_STEP=256, HOLD_CYCLES=8.
- Reset, then rearm pulse at cycle 3 -> dropped (hold not done), state stays SAFE. Rearm at cycle 10 -> state RUN. amp_in=0x1234 appears on amp_out one cycle later; rf_enable=1.
- In RUN with amp_in=0x1000, assert wdt_warning -> DERATE, amp_out=0x0800. Deassert warning -> RUN, amp_out=0x1000.
- In RUN with amp_out=0x0500, assert wdt_triggered for 1 cycle:
  - amp_out sequence 0x0400, 0x0300, 0x0200, 0x0100, 0x0000.
  - Then SAFE, rf_enable=0, fault_count=1.
  - The ramp continues despite triggered dropping.
- In SAFE with hold_done=1 but wdt_triggered=1, pulse rearm -> stays SAFE. Drop triggered, pulse rearm -> RUN.
- Warning and triggered asserted together in RUN -> RAMP, not DERATE. Assert rst during RAMP -> amp_out=0, state_o=3, fault_count=0 immediately.
- 300 trigger/rearm cycles -> fault_count saturates at 255. With SHUTDOWN_AUTO_REARM_EN defined -> RUN is reached 8 cycles after SAFE entry with no rearm pulse.
